flagsunit: RTL

//  Producer of the NZVC condition flags consumed by branch control.

---
 rtl/flagsunit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/flagsunit.sv
// NZVC flag producer: computes flags in execute, stages them one cycle, then commits to arch.
// Optional FLAGS_SAVE_EN adds a shadow register with save/restore ports.
module flagsunit #(
  parameter int  WIDTH    = 64,
  localparam int FLAGSIZE = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                setflags,
  input  logic [1:0]          flagop,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    result,
  input  logic [FLAGSIZE-1:0] wdata,
  input  logic                stall,
  input  logic                flush,
`ifdef FLAGS_SAVE_EN
  input  logic                save,
  input  logic                restore,
  output logic [FLAGSIZE-1:0] savedflags,
`endif
  output logic [FLAGSIZE-1:0] flags,
  output logic [FLAGSIZE-1:0] flagsarch,
  output logic                pendvalid
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;

  // Subtraction is a + ~b + 1, so c=1 means no borrow and v compares against ~b.
  function automatic logic [FLAGSIZE-1:0] addsub_flags(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sub
  );
    logic [WIDTH-1:0] yb;
    logic [WIDTH:0]   sum;
    logic             n, z, v, c;
    yb  = sub ? ~y : y;
    sum = {1'b0, x} + {1'b0, yb} + {{WIDTH{1'b0}}, sub};
    n   = sum[WIDTH-1];
    z   = (sum[WIDTH-1:0] == '0);
    v   = (x[WIDTH-1] == yb[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    c   = sum[WIDTH];
    return {n, z, v, c};
  endfunction

  function automatic logic [FLAGSIZE-1:0] logic_flags(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0), 1'b0, 1'b0};
  endfunction

  logic [FLAGSIZE-1:0] newflags_p0;
  logic [FLAGSIZE-1:0] pend_p1, pend_nxt;
  logic                vld_p1, vld_nxt;
  logic [FLAGSIZE-1:0] arch_p2, arch_nxt;

  // ---- p0: execute-stage flag computation ----
  always_comb begin
    newflags_p0 = '0;
    case (flagop)
      OP_ADD:   newflags_p0 = addsub_flags(a, b, 1'b0);
      OP_SUB:   newflags_p0 = addsub_flags(a, b, 1'b1);
      OP_LOGIC: newflags_p0 = logic_flags(result);
      default:  newflags_p0 = wdata;
    endcase
  end

`ifdef FLAGS_SAVE_EN
  logic [FLAGSIZE-1:0] shadow;
`endif

  // Next-state for pending/arch; stall freezes everything, restore beats flush/commit/load.
  always_comb begin
    pend_nxt = pend_p1;
    vld_nxt  = vld_p1;
    arch_nxt = arch_p2;
    if (!stall) begin
      if (flush) begin
        vld_nxt = 1'b0;
      end else begin
        if (vld_p1) arch_nxt = pend_p1;
        if (setflags) begin
          pend_nxt = newflags_p0;
          vld_nxt  = 1'b1;
        end else begin
          vld_nxt  = 1'b0;
        end
      end
`ifdef FLAGS_SAVE_EN
      if (restore) begin
        arch_nxt = shadow;
        vld_nxt  = 1'b0;
        pend_nxt = pend_p1;
      end
`endif
    end
  end

  // ---- p1: pending register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      pend_p1 <= pend_nxt;
      vld_p1  <= vld_nxt;
    end
  end

  // ---- p2: architectural register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) arch_p2 <= '0;
    else       arch_p2 <= arch_nxt;
  end

  // Youngest value wins so a dependent branch right after an S-op sees it.
  always_comb flags = vld_p1 ? pend_p1 : arch_p2;

  assign flagsarch = arch_p2;
  assign pendvalid = vld_p1;

`ifdef FLAGS_SAVE_EN
  // Shadow captures the forwarded (pre-edge) flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                shadow <= '0;
    else if (!stall && save)  shadow <= flags;
  end

  assign savedflags = shadow;
`endif

endmodule
